// File: rtl/movi_unit_pkg.sv
// Shared encodings for the move-immediate functional unit.
// Holds the operation modes and destination location-type tags.
`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 6
`endif

package movi_unit_pkg;

    typedef enum logic [1:0] {
        MODE_MOVL = 2'd0,
        MODE_MOVZ = 2'd1,
        MODE_MOVH = 2'd2,
        MODE_MOV  = 2'd3
    } mode_e;

    localparam logic [1:0] LOC_TYPE_REG = 2'b00;

endpackage

// File: rtl/movi_unit_if.sv
// Issue and writeback handshake bundle of the move-immediate unit.
// The master modport is the issue/writeback side; slave is the unit.
interface movi_unit_if #(
    parameter int DATA_W = 16,
    parameter int UID_W  = `ROB_QUEUE_BITS,
    parameter int LOC_W  = 18,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [UID_W-1:0]         in_uid;
    logic [1:0]               in_mode;
    logic [2:0][DATA_W-1:0]   params;

    logic                     out_valid;
    logic                     out_ready;
    logic [UID_W-1:0]         out_uid;
    logic [DATA_W-1:0]        result_val;
    logic [LOC_W-1:0]         out_loc;
    logic [CNT_W-1:0]         occupancy;

    modport master (
        output in_valid, in_uid, in_mode, params, out_ready,
        input  in_ready, out_valid, out_uid, result_val,
        input  out_loc, occupancy
    );

    modport slave (
        input  in_valid, in_uid, in_mode, params, out_ready,
        output in_ready, out_valid, out_uid, result_val,
        output out_loc, occupancy
    );

endinterface

// File: rtl/fu_out_fifo.sv
// Result queue for a functional unit: strict FIFO with flush.
// Storage is not reset; only pointers and count are.
module fu_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_data;
    end

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/movi_unit.sv
// Move-immediate unit: decodes the mode, forms the result at
// issue and queues {uid, result, loc} for writeback.
module movi_unit
    import movi_unit_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8,
    parameter int UID_W  = `ROB_QUEUE_BITS,
    parameter int LOC_W  = 18,
    parameter int DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    movi_unit_if.slave bus
);
    localparam int ENT_W = UID_W + DATA_W + LOC_W;
    localparam int HI_W  = DATA_W - IMM_W;

    mode_e                w_mode;
    logic [IMM_W-1:0]     w_imm;
    logic [DATA_W-1:0]    w_result;
    logic [LOC_W-1:0]     w_loc;
    logic [ENT_W-1:0]     w_wr_data;
    logic [ENT_W-1:0]     w_rd_data;
    logic [UID_W-1:0]     w_h_uid;
    logic [DATA_W-1:0]    w_h_res;
    logic [LOC_W-1:0]     w_h_loc;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_unused_hi;

    assign w_mode = mode_e'(bus.in_mode);
    assign w_imm  = bus.params[1][IMM_W-1:0];
    assign w_loc  = {LOC_TYPE_REG, (LOC_W-2)'(bus.params[0])};

    // MOVH keeps only the low part of the old destination value.
    assign w_unused_hi = &{1'b0, bus.params[2][DATA_W-1:HI_W]};

    always_comb begin
        w_result = bus.params[1];
        unique case (w_mode)
            MODE_MOVL: w_result = {{HI_W{w_imm[IMM_W-1]}}, w_imm};
            MODE_MOVZ: w_result = {{HI_W{1'b0}}, w_imm};
            MODE_MOVH: w_result = {w_imm, bus.params[2][HI_W-1:0]};
            MODE_MOV:  w_result = bus.params[1];
        endcase
    end

    assign bus.in_ready = rst_n && !w_full && !flush;
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = bus.out_valid && bus.out_ready && !flush;
    assign w_wr_data    = {bus.in_uid, w_result, w_loc};

    fu_out_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_data  (w_wr_data),
        .o_data  (w_rd_data),
        .o_count (bus.occupancy),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {w_h_uid, w_h_res, w_h_loc} = w_rd_data;

    // Unwritten storage must never leak out, so gate by valid.
    assign bus.out_valid  = !w_empty;
    assign bus.out_uid    = bus.out_valid ? w_h_uid : '0;
    assign bus.result_val = bus.out_valid ? w_h_res : '0;
    assign bus.out_loc    = bus.out_valid ? w_h_loc : '0;

endmodule
